tb_sim_ctrl: RTL and testbench

- Parametrised simulation-control block for the X-ALP testharness.
- Sequences the DUT reset: drives the DUT's active-low reset through a hold phase, then releases it.
- Collects exit requests from NUM_CH independent exit channels (cores, accelerators, secondary SoCs) and reports a single sticky exit status.
- Adds a cycle-count watchdog that forces a timeout exit when the run hangs.

---
 rtl/tb_sim_ctrl.sv | 150 +++++++++++++++
 tb/tb_tb_sim_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/tb_sim_ctrl.sv
// Simulation control block: DUT reset sequencing, exit-channel capture and a run watchdog.
// Build macro TB_SIM_CTRL_WAIT_ALL_EN: wait for every channel before reporting the exit.
module tb_sim_ctrl #(
  parameter int              NUM_CH       = 2,
  parameter int              DATA_W       = 32,
  parameter int              RST_CYCLES   = 16,
  parameter int              TIMEOUT_W    = 32,
  parameter longint unsigned TIMEOUT_VAL  = 1_000_000,
  parameter logic [31:0]     TIMEOUT_CODE = 32'hDEAD_0001
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  output logic                                          dut_rst_no,
  input  logic [NUM_CH-1:0]                             ch_valid_i,
  input  logic [NUM_CH*DATA_W-1:0]                      ch_value_i,
  output logic [NUM_CH-1:0]                             ch_ack_o,
  output logic                                          exit_valid_o,
  output logic [DATA_W-1:0]                             exit_value_o,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] exit_ch_o,
  output logic                                          timeout_o,
  output logic [TIMEOUT_W-1:0]                          cycle_cnt_o,
  output logic [1:0]                                    dbg_state_o
);
  localparam int                    CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int                    HOLD_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]     HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam bit                    TO_EN     = (TIMEOUT_VAL != 0);
  localparam logic [TIMEOUT_W-1:0]  TO_LAST   = TIMEOUT_W'(TIMEOUT_VAL - 1);
  localparam logic [DATA_W-1:0]     TO_CODE   = DATA_W'(TIMEOUT_CODE);

  if ((TIMEOUT_VAL >> TIMEOUT_W) != 0) begin : g_bad_timeout
    $error("TIMEOUT_VAL does not fit in TIMEOUT_W bits");
  end
  if (NUM_CH < 1 || NUM_CH > 16 || RST_CYCLES < 1) begin : g_bad_params
    $error("NUM_CH must be 1..16 and RST_CYCLES >= 1");
  end

  typedef enum logic [1:0] {S_HOLD, S_RUN, S_DONE, S_TIMEOUT} state_t;

  state_t                r_state, w_state_nxt;
  logic [HOLD_W-1:0]     r_hold_cnt;
  logic [TIMEOUT_W-1:0]  r_cycle_cnt;
  logic                  r_exit_valid;
  logic [DATA_W-1:0]     r_exit_value;
  logic [CH_W-1:0]       r_exit_ch;
  logic                  r_timeout;
  logic [NUM_CH-1:0]     r_ack;

  logic [NUM_CH-1:0]     w_cap;
  logic                  w_exit;
  logic                  w_to_hit;
  logic [CH_W-1:0]       w_sel_ch;
  logic [DATA_W-1:0]     w_sel_val;
`ifdef TB_SIM_CTRL_WAIT_ALL_EN
  logic [NUM_CH-1:0]     r_done;
  logic [DATA_W-1:0]     r_val [NUM_CH];
  logic [NUM_CH-1:0]     w_done_nxt;
  logic [DATA_W-1:0]     w_val_nxt [NUM_CH];
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cap       = '0;
    w_exit      = 1'b0;
    w_sel_ch    = '0;
    w_sel_val   = '0;
    w_to_hit    = TO_EN && (r_cycle_cnt == TO_LAST);
`ifdef TB_SIM_CTRL_WAIT_ALL_EN
    w_done_nxt = r_done;
    if (r_state == S_RUN) begin
      w_cap      = ch_valid_i & ~r_done;
      w_done_nxt = r_done | w_cap;
    end
    for (int k = 0; k < NUM_CH; k++)
      w_val_nxt[k] = w_cap[k] ? ch_value_i[k*DATA_W +: DATA_W] : r_val[k];
    // Reported value: lowest-index finished channel with a nonzero value.
    for (int k = NUM_CH-1; k >= 0; k--) begin
      if (w_done_nxt[k] && (w_val_nxt[k] != '0)) begin
        w_sel_ch  = CH_W'(k);
        w_sel_val = w_val_nxt[k];
      end
    end
    w_exit = (r_state == S_RUN) && (&w_done_nxt);
`else
    // Descending scan so the lowest-index valid channel wins.
    for (int k = NUM_CH-1; k >= 0; k--) begin
      if (ch_valid_i[k]) begin
        w_exit    = (r_state == S_RUN);
        w_sel_ch  = CH_W'(k);
        w_sel_val = ch_value_i[k*DATA_W +: DATA_W];
      end
    end
    if (w_exit) w_cap = NUM_CH'(1) << w_sel_ch;
`endif
    case (r_state)
      S_HOLD:  if (r_hold_cnt == HOLD_LAST) w_state_nxt = S_RUN;
      S_RUN:   if (w_exit) w_state_nxt = S_DONE;
               else if (w_to_hit) w_state_nxt = S_TIMEOUT;
      default: w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_HOLD;
      r_hold_cnt   <= '0;
      r_cycle_cnt  <= '0;
      r_exit_valid <= 1'b0;
      r_exit_value <= '0;
      r_exit_ch    <= '0;
      r_timeout    <= 1'b0;
      r_ack        <= '0;
`ifdef TB_SIM_CTRL_WAIT_ALL_EN
      r_done       <= '0;
      for (int k = 0; k < NUM_CH; k++) r_val[k] <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_cap;
      if (r_state == S_HOLD) r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
      if (r_state == S_RUN) begin
        if (r_cycle_cnt != '1) r_cycle_cnt <= r_cycle_cnt + TIMEOUT_W'(1);
`ifdef TB_SIM_CTRL_WAIT_ALL_EN
        r_done <= w_done_nxt;
        for (int k = 0; k < NUM_CH; k++) r_val[k] <= w_val_nxt[k];
`endif
      end
      if (r_state == S_RUN && w_state_nxt == S_DONE) begin
        r_exit_valid <= 1'b1;
        r_exit_value <= w_sel_val;
        r_exit_ch    <= w_sel_ch;
      end
      if (r_state == S_RUN && w_state_nxt == S_TIMEOUT) begin
        r_exit_valid <= 1'b1;
        r_timeout    <= 1'b1;
        r_exit_value <= TO_CODE;
        r_exit_ch    <= '0;
      end
    end
  end

  assign dut_rst_no   = (r_state != S_HOLD);
  assign ch_ack_o     = r_ack;
  assign exit_valid_o = r_exit_valid;
  assign exit_value_o = r_exit_value;
  assign exit_ch_o    = r_exit_ch;
  assign timeout_o    = r_timeout;
  assign cycle_cnt_o  = r_cycle_cnt;
  assign dbg_state_o  = r_state;
endmodule

// File: tb/tb_tb_sim_ctrl.sv
// Directed bench for tb_sim_ctrl: reset hold, exits, priority, watchdog and mid-run reset.
module tb_tb_sim_ctrl;
  localparam int NUM_CH = 2;
  localparam int DATA_W = 32;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     dut_rst_n;
  logic [NUM_CH-1:0]        ch_valid = '0;
  logic [DATA_W-1:0]        val0 = '0;
  logic [DATA_W-1:0]        val1 = '0;
  logic [NUM_CH-1:0]        ch_ack;
  logic                     exit_valid;
  logic [DATA_W-1:0]        exit_value;
  logic [0:0]               exit_ch;
  logic                     timeout;
  logic [31:0]              cycle_cnt;
  logic [1:0]               dbg_state;

  int n_vec  = 0;
  int n_miss = 0;

  tb_sim_ctrl #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .RST_CYCLES(16), .TIMEOUT_W(32),
    .TIMEOUT_VAL(100), .TIMEOUT_CODE(32'hDEAD_0001)
  ) dut (
    .clk_i(clk), .rst_i(rst), .dut_rst_no(dut_rst_n),
    .ch_valid_i(ch_valid), .ch_value_i({val1, val0}), .ch_ack_o(ch_ack),
    .exit_valid_o(exit_valid), .exit_value_o(exit_value), .exit_ch_o(exit_ch),
    .timeout_o(timeout), .cycle_cnt_o(cycle_cnt), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " state"},     64'(dbg_state), 64'd0);
    check({tag, " rst_n"},     64'(dut_rst_n), 64'd0);
    check({tag, " ack"},       64'(ch_ack), 64'd0);
    check({tag, " exit_v"},    64'(exit_valid), 64'd0);
    check({tag, " exit_val"},  64'(exit_value), 64'd0);
    check({tag, " exit_ch"},   64'(exit_ch), 64'd0);
    check({tag, " timeout"},   64'(timeout), 64'd0);
    check({tag, " cycle_cnt"}, 64'(cycle_cnt), 64'd0);
  endtask

  // Reset asserted for n cycles, then released and walked through the 16-cycle hold.
  task automatic reset_and_hold(input int n);
    rst = 1'b1;
    ch_valid = '0;
    tick(n);
    check_reset_vals("rst");
    rst = 1'b0;
    ch_valid = 2'b11;
    for (int i = 1; i <= 15; i++) begin
      tick(1);
      check("hold rst_n", 64'(dut_rst_n), 64'd0);
      check("hold ack", 64'(ch_ack), 64'd0);
    end
    ch_valid = '0;
    tick(1);
    check("run rst_n", 64'(dut_rst_n), 64'd1);
    check("run state", 64'(dbg_state), 64'd1);
    check("run cnt0", 64'(cycle_cnt), 64'd0);
  endtask

  initial begin
    tick(1);
    reset_and_hold(3);

`ifdef TB_SIM_CTRL_WAIT_ALL_EN
    tick(4);
    val0 = 32'd0;
    ch_valid = 2'b01;
    tick(1);
    ch_valid = '0;
    check("wa ack0", 64'(ch_ack), 64'd1);
    check("wa not yet", 64'(exit_valid), 64'd0);
    tick(3);
    val1 = 32'd3;
    ch_valid = 2'b10;
    tick(1);
    ch_valid = '0;
    check("wa ack1", 64'(ch_ack), 64'd2);
    check("wa exit_v", 64'(exit_valid), 64'd1);
    check("wa value", 64'(exit_value), 64'd3);
    check("wa ch", 64'(exit_ch), 64'd1);
`else
    val1 = 32'h0000_0000;
    ch_valid = 2'b10;
    tick(1);
    check("single exit_v", 64'(exit_valid), 64'd1);
    check("single value", 64'(exit_value), 64'd0);
    check("single ch", 64'(exit_ch), 64'd1);
    check("single ack", 64'(ch_ack), 64'd2);
    check("single cnt", 64'(cycle_cnt), 64'd1);
    tick(1);
    check("single ack pulse", 64'(ch_ack), 64'd0);
    tick(3);
    check("done cnt frozen", 64'(cycle_cnt), 64'd1);
    check("done rst_n", 64'(dut_rst_n), 64'd1);
    check("done state", 64'(dbg_state), 64'd2);

    reset_and_hold(1);
    val0 = 32'd5;
    val1 = 32'd7;
    ch_valid = 2'b11;
    tick(1);
    check("prio value", 64'(exit_value), 64'd5);
    check("prio ch", 64'(exit_ch), 64'd0);
    check("prio ack", 64'(ch_ack), 64'd1);
    ch_valid = 2'b10;
    val1 = 32'd9;
    tick(2);
    check("prio late ack", 64'(ch_ack), 64'd0);
    check("prio hold value", 64'(exit_value), 64'd5);
    ch_valid = '0;
`endif

    // Mid-run reset from DONE: one-cycle pulse gives the full hold again.
    reset_and_hold(1);

    tick(99);
    check("to before", 64'(exit_valid), 64'd0);
    check("to cnt99", 64'(cycle_cnt), 64'd99);
    tick(1);
    check("to exit_v", 64'(exit_valid), 64'd1);
    check("to flag", 64'(timeout), 64'd1);
    check("to value", 64'(exit_value), 64'hDEAD_0001);
    check("to ch", 64'(exit_ch), 64'd0);
    check("to state", 64'(dbg_state), 64'd3);
    ch_valid = 2'b01;
    tick(3);
    check("to cnt frozen", 64'(cycle_cnt), 64'd100);
    check("to no ack", 64'(ch_ack), 64'd0);
    ch_valid = '0;

`ifndef TB_SIM_CTRL_WAIT_ALL_EN
    reset_and_hold(2);
    tick(99);
    val0 = 32'h0000_1234;
    ch_valid = 2'b01;
    tick(1);
    ch_valid = '0;
    check("race exit_v", 64'(exit_valid), 64'd1);
    check("race timeout", 64'(timeout), 64'd0);
    check("race value", 64'(exit_value), 64'h1234);
    check("race ack", 64'(ch_ack), 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
